// File: rtl/jtshouse_scr_pkg.sv
// Shared definitions for the scroll/layer register file: byte offsets of each
// field inside a register bank and the state encoding of the copy engine.
// No logic; constant functions only.
package jtshouse_scr_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        COPY = 1'b1
    } copy_st_t;

    // hscr[n] occupies bytes 4n (high) and 4n+1 (low)
    function automatic int SCR_HOFF(input int n);
        return 4 * n;
    endfunction

    // vscr[n] occupies bytes 4n+2 (high) and 4n+3 (low)
    function automatic int SCR_VOFF(input int n);
        return 4 * n + 2;
    endfunction

    // enable/priority bytes follow the scroll block
    function automatic int PRIO_OFF(input int scrl);
        return 4 * scrl;
    endfunction

    // palette bytes start 8 bytes after the enable/priority block
    function automatic int PAL_OFF(input int scrl);
        return 4 * scrl + 8;
    endfunction

endpackage

// File: rtl/jtshouse_scr_copy.sv
// Copy sequencer: walks ptr over every bank byte once per vblank rising edge.
// Latency: busy one cycle after the edge; 2^AW cycles of copy; upd on the last one.
// Backpressure: none; edges seen while busy are dropped, the copy never restarts.
module jtshouse_scr_copy #(
    parameter int AW = 5
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          vbl,
    output logic          busy,
    output logic          upd,
    output logic [AW-1:0] ptr
);
    import jtshouse_scr_pkg::*;

    copy_st_t      r_st, w_st_nxt;
    logic [AW-1:0] r_ptr, w_ptr_nxt;
    logic          r_vbl_l;
    logic          w_trig;

    assign w_trig = vbl & ~r_vbl_l;
    assign ptr    = r_ptr;

    // state, pointer and vblank history registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st    <= IDLE;
            r_ptr   <= '0;
            r_vbl_l <= 1'b0;
        end else begin
            r_st    <= w_st_nxt;
            r_ptr   <= w_ptr_nxt;
            r_vbl_l <= vbl;
        end
    end

    // next state; upd marks the cycle in which the final byte is copied
    always_comb begin
        w_st_nxt  = r_st;
        w_ptr_nxt = r_ptr;
        busy      = 1'b0;
        upd       = 1'b0;
        case (r_st)
            IDLE: begin
                if (w_trig) begin
                    w_st_nxt  = COPY;
                    w_ptr_nxt = '0;
                end
            end
            COPY: begin
                busy      = 1'b1;
                w_ptr_nxt = r_ptr + 1'b1;
                if (r_ptr == {AW{1'b1}}) begin
                    w_st_nxt = IDLE;
                    upd      = 1'b1;
                end
            end
            default: w_st_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/jtshouse_scr_mmr_dbuf.sv
// Scroll/layer register file; with JTSHOUSE_SCR_DBUF_EN the CPU writes a pending
// bank copied to the active bank each vblank. Reads: 1 cycle; fields: combinational.
// Backpressure: none; CPU writes always accepted, even during a copy.
module jtshouse_scr_mmr_dbuf #(
    parameter int SCRL   = 4,
    parameter int LAYERS = 6,
    parameter int AW     = 5
) (
    input  logic                 rst,
    input  logic                 clk,
    input  logic                 cs,
    input  logic [AW-1:0]        addr,
    input  logic                 rnw,
    input  logic [7:0]           din,
    output logic [7:0]           dout,
    input  logic                 vbl,
    output logic                 busy,
    output logic                 upd,
    output logic [16*SCRL-1:0]   hscr,
    output logic [16*SCRL-1:0]   vscr,
    output logic [LAYERS-1:0]    enb,
    output logic [3*LAYERS-1:0]  prio,
    output logic [3*LAYERS-1:0]  pal,
    input  logic [AW-1:0]        ioctl_addr,
    output logic [7:0]           ioctl_din,
    input  logic [7:0]           debug_bus,
    output logic [7:0]           st_dout
);
    import jtshouse_scr_pkg::*;

    localparam int DEPTH  = 2 ** AW;
    localparam int PRIO_O = PRIO_OFF(SCRL);
    localparam int PAL_O  = PAL_OFF(SCRL);

    logic [7:0] r_act [DEPTH];
    logic [7:0] r_dout, r_ioctl_din, r_st_dout;
    logic       w_wr;
    logic       w_unused;

    assign w_wr      = cs & ~rnw;
    assign dout      = r_dout;
    assign ioctl_din = r_ioctl_din;
    assign st_dout   = r_st_dout;

`ifdef JTSHOUSE_SCR_DBUF_EN
    logic [7:0]    r_pend [DEPTH];
    logic [AW-1:0] w_ptr;

    assign w_unused = ^debug_bus;

    jtshouse_scr_copy #(.AW(AW)) u_copy (
        .rst  (rst),
        .clk  (clk),
        .vbl  (vbl),
        .busy (busy),
        .upd  (upd),
        .ptr  (w_ptr)
    );

    // CPU writes land in the pending bank only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_pend[i] <= 8'd0;
        end else if (w_wr) begin
            r_pend[addr] <= din;
        end
    end

    // copy one byte per busy cycle; a CPU write to the byte being copied wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_act[i] <= 8'd0;
        end else if (busy) begin
            r_act[w_ptr] <= (w_wr && addr == w_ptr) ? din : r_pend[w_ptr];
        end
    end

    // registered read ports: CPU and dump see pending, debug sees active
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout      <= 8'd0;
            r_ioctl_din <= 8'd0;
            r_st_dout   <= 8'd0;
        end else begin
            r_dout      <= r_pend[addr];
            r_ioctl_din <= r_pend[ioctl_addr];
            r_st_dout   <= r_act[debug_bus[AW-1:0]];
        end
    end
`else
    assign busy     = 1'b0;
    assign upd      = 1'b0;
    assign w_unused = ^{vbl, debug_bus};

    // single bank: CPU writes go straight to the active registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_act[i] <= 8'd0;
        end else if (w_wr) begin
            r_act[addr] <= din;
        end
    end

    // registered read ports, all served by the one bank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout      <= 8'd0;
            r_ioctl_din <= 8'd0;
            r_st_dout   <= 8'd0;
        end else begin
            r_dout      <= r_act[addr];
            r_ioctl_din <= r_act[ioctl_addr];
            r_st_dout   <= r_act[debug_bus[AW-1:0]];
        end
    end
`endif

    // scroll fields are big-endian byte pairs
    for (genvar n = 0; n < SCRL; n++) begin : g_scr
        assign hscr[16*n +: 16] = {r_act[SCR_HOFF(n)], r_act[SCR_HOFF(n) + 1]};
        assign vscr[16*n +: 16] = {r_act[SCR_VOFF(n)], r_act[SCR_VOFF(n) + 1]};
    end

    // per-layer enable, priority and palette
    for (genvar n = 0; n < LAYERS; n++) begin : g_lyr
        assign enb[n]         = r_act[PRIO_O + n][3];
        assign prio[3*n +: 3] = r_act[PRIO_O + n][2:0];
        assign pal[3*n +: 3]  = r_act[PAL_O + n][2:0];
    end

endmodule

// File: tb/tb_jtshouse_scr_mmr_dbuf.sv
// Directed bench for the scroll/layer register file, single or double buffered.
// Inputs are driven 1 time unit after the rising edge and sampled there.
// Bounded waits count as failures so the run always reaches its summary.
module tb_jtshouse_scr_mmr_dbuf;

    logic        rst, clk, cs, rnw, vbl;
    logic [4:0]  addr, ioctl_addr;
    logic [7:0]  din, dout, ioctl_din, debug_bus, st_dout;
    logic        busy, upd;
    logic [63:0] hscr, vscr;
    logic [5:0]  enb;
    logic [17:0] prio, pal;

    int errors = 0;
    int checks = 0;

    jtshouse_scr_mmr_dbuf #(.SCRL(4), .LAYERS(6), .AW(5)) dut (
        .rst(rst), .clk(clk), .cs(cs), .addr(addr), .rnw(rnw), .din(din),
        .dout(dout), .vbl(vbl), .busy(busy), .upd(upd), .hscr(hscr),
        .vscr(vscr), .enb(enb), .prio(prio), .pal(pal),
        .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din),
        .debug_bus(debug_bus), .st_dout(st_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_wr(input logic [4:0] a, input logic [7:0] d);
        cs = 1'b1; rnw = 1'b0; addr = a; din = d;
        tick();
        cs = 1'b0; rnw = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; vbl = 1'b0;
        #1;
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (upd !== 1'b0)    begin errors++; $display("FAIL reset_upd: got %b want 0", upd); end
        checks++; if (hscr !== 64'h0 || vscr !== 64'h0) begin errors++; $display("FAIL reset_scroll: got %h/%h want 0", hscr, vscr); end
        checks++; if (enb !== 6'h0 || prio !== 18'h0 || pal !== 18'h0) begin errors++; $display("FAIL reset_layer: got %h/%h/%h want 0", enb, prio, pal); end
        checks++; if (dout !== 8'h0 || ioctl_din !== 8'h0 || st_dout !== 8'h0) begin errors++; $display("FAIL reset_reads: got %h/%h/%h want 0", dout, ioctl_din, st_dout); end
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

`ifdef JTSHOUSE_SCR_DBUF_EN
    // vblank edge then wait until the copy finishes
    task automatic vblank();
        int n;
        vbl = 1'b0; tick();
        vbl = 1'b1; tick();
        n = 0;
        while (busy === 1'b1 && n < 100) begin tick(); n++; end
        checks++; if (n >= 100) begin errors++; $display("FAIL copy_timeout: busy still %b after %0d cycles want 0", busy, n); end
        tick();
    endtask

    task automatic test_pending();
        cpu_wr(5'd0, 8'h12);
        cpu_wr(5'd1, 8'h34);
        addr = 5'd0;
        tick();
        checks++; if (hscr[15:0] !== 16'h0000) begin errors++; $display("FAIL pending_hold: got %h want 0000", hscr[15:0]); end
        checks++; if (dout !== 8'h12) begin errors++; $display("FAIL pending_dout: got %h want 12", dout); end
    endtask

    task automatic test_copy();
        int nb, nu;
        vbl = 1'b0; tick();
        vbl = 1'b1; tick();
        checks++; if (busy !== 1'b1 || hscr[15:0] !== 16'h0000) begin errors++; $display("FAIL copy_start: busy=%b hscr=%h want 1/0000", busy, hscr[15:0]); end
        tick();
        checks++; if (hscr[15:0] !== 16'h1200) begin errors++; $display("FAIL copy_byte0: got %h want 1200", hscr[15:0]); end
        tick();
        checks++; if (hscr[15:0] !== 16'h1234) begin errors++; $display("FAIL copy_byte1: got %h want 1234", hscr[15:0]); end
        nb = 3; nu = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (busy === 1'b1) nb++;
            if (upd === 1'b1) nu++;
        end
        checks++; if (nb !== 32) begin errors++; $display("FAIL copy_busy_len: got %0d want 32", nb); end
        checks++; if (nu !== 1)  begin errors++; $display("FAIL copy_upd_cnt: got %0d want 1", nu); end
    endtask

    task automatic test_prio();
        cpu_wr(5'd18, 8'h0B);
        checks++; if (enb[2] !== 1'b0) begin errors++; $display("FAIL prio_early: got %b want 0", enb[2]); end
        vblank();
        checks++; if (enb[2] !== 1'b1 || prio[8:6] !== 3'd3) begin errors++; $display("FAIL prio_copy: enb=%b prio=%0d want 1/3", enb[2], prio[8:6]); end
    endtask

    task automatic test_collision();
        vbl = 1'b0; tick();
        vbl = 1'b1; tick();            // ptr = 0
        repeat (5) tick();             // ptr = 5
        cpu_wr(5'd5, 8'h55);           // ptr = 6
        repeat (4) tick();             // ptr = 10
        cpu_wr(5'd2, 8'h66);
        for (int i = 0; i < 40 && busy === 1'b1; i++) tick();
        tick();
        checks++; if (hscr[31:16] !== 16'h0055) begin errors++; $display("FAIL collide_same: got %h want 0055", hscr[31:16]); end
        checks++; if (vscr[15:0] !== 16'h0000) begin errors++; $display("FAIL collide_behind: got %h want 0000", vscr[15:0]); end
        debug_bus = 8'hE5; addr = 5'd2; ioctl_addr = 5'd5;
        tick();
        checks++; if (st_dout !== 8'h55) begin errors++; $display("FAIL st_dout_act: got %h want 55", st_dout); end
        checks++; if (dout !== 8'h66 || ioctl_din !== 8'h55) begin errors++; $display("FAIL pend_reads: got %h/%h want 66/55", dout, ioctl_din); end
        vblank();
        checks++; if (vscr[15:0] !== 16'h6600) begin errors++; $display("FAIL collide_next: got %h want 6600", vscr[15:0]); end
    endtask

    task automatic test_back_to_back();
        int nb, nu;
        nb = 0; nu = 0;
        vbl = 1'b0; tick();
        vbl = 1'b1;
        for (int i = 0; i < 80; i++) begin
            if (i == 6) vbl = 1'b0;
            if (i == 8) vbl = 1'b1;
            tick();
            if (busy === 1'b1) nb++;
            if (upd === 1'b1) nu++;
        end
        checks++; if (nb !== 32) begin errors++; $display("FAIL retrig_busy: got %0d want 32", nb); end
        checks++; if (nu !== 1)  begin errors++; $display("FAIL retrig_upd: got %0d want 1", nu); end
    endtask

    task automatic test_reset_midcopy();
        vbl = 1'b0; tick();
        vbl = 1'b1; tick();
        repeat (20) tick();            // ptr = 20
        rst = 1'b1; vbl = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || upd !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b/%b want 0/0", busy, upd); end
        checks++; if (hscr !== 64'h0 || vscr !== 64'h0 || enb !== 6'h0 || prio !== 18'h0 || pal !== 18'h0) begin errors++; $display("FAIL midrst_fields: got %h %h %h %h %h want 0", hscr, vscr, enb, prio, pal); end
        checks++; if (dout !== 8'h0 || ioctl_din !== 8'h0 || st_dout !== 8'h0) begin errors++; $display("FAIL midrst_reads: got %h/%h/%h want 0", dout, ioctl_din, st_dout); end
        tick();
        rst = 1'b0; addr = 5'd0; ioctl_addr = 5'd1;
        tick(); tick();
        checks++; if (busy !== 1'b0 || dout !== 8'h0 || ioctl_din !== 8'h0) begin errors++; $display("FAIL midrst_after: busy=%b dout=%h ioctl=%h want 0", busy, dout, ioctl_din); end
    endtask
`else
    task automatic test_direct();
        cpu_wr(5'd24, 8'h07);
        checks++; if (pal[2:0] !== 3'd7 || pal[17:3] !== 15'h0) begin errors++; $display("FAIL direct_pal: got %h want 00007", pal); end
        cpu_wr(5'd0, 8'h12);
        cpu_wr(5'd1, 8'h34);
        checks++; if (hscr[15:0] !== 16'h1234) begin errors++; $display("FAIL direct_hscr: got %h want 1234", hscr[15:0]); end
        cpu_wr(5'd18, 8'h0B);
        checks++; if (enb !== 6'b000100 || prio[8:6] !== 3'd3) begin errors++; $display("FAIL direct_prio: enb=%b prio=%h want 000100/3", enb, prio[8:6]); end
        cpu_wr(5'd14, 8'hA5);
        cpu_wr(5'd15, 8'h5A);
        checks++; if (vscr[63:48] !== 16'hA55A || vscr[47:0] !== 48'h0) begin errors++; $display("FAIL direct_vscr: got %h want a55a000000000000", vscr); end
    endtask

    task automatic test_reads();
        cs = 1'b1; rnw = 1'b1; din = 8'hFF; addr = 5'd0;
        ioctl_addr = 5'd1; debug_bus = 8'hF8;
        tick();
        cs = 1'b0;
        checks++; if (dout !== 8'h12) begin errors++; $display("FAIL read_dout: got %h want 12", dout); end
        checks++; if (ioctl_din !== 8'h34) begin errors++; $display("FAIL read_ioctl: got %h want 34", ioctl_din); end
        checks++; if (st_dout !== 8'h07) begin errors++; $display("FAIL read_st: got %h want 07", st_dout); end
        cs = 1'b0; rnw = 1'b0; addr = 5'd0; din = 8'hEE;
        tick();
        rnw = 1'b1;
        checks++; if (hscr[15:0] !== 16'h1234) begin errors++; $display("FAIL no_cs_write: got %h want 1234", hscr[15:0]); end
    endtask

    task automatic test_vbl_ignored();
        int nb, nu;
        nb = 0; nu = 0;
        for (int i = 0; i < 40; i++) begin
            vbl = (i % 10) < 5;
            tick();
            if (busy !== 1'b0) nb++;
            if (upd !== 1'b0) nu++;
        end
        checks++; if (nb !== 0 || nu !== 0) begin errors++; $display("FAIL vbl_ignored: busy_cycles=%0d upd_cycles=%0d want 0/0", nb, nu); end
        checks++; if (hscr[15:0] !== 16'h1234 || pal[2:0] !== 3'd7) begin errors++; $display("FAIL vbl_fields: got %h/%0d want 1234/7", hscr[15:0], pal[2:0]); end
        rst = 1'b1;
        #1;
        checks++; if (hscr !== 64'h0 || vscr !== 64'h0 || enb !== 6'h0 || prio !== 18'h0 || pal !== 18'h0 || st_dout !== 8'h0) begin errors++; $display("FAIL rerst_fields: got %h %h %h %h %h %h want 0", hscr, vscr, enb, prio, pal, st_dout); end
        tick();
        rst = 1'b0;
        tick();
    endtask
`endif

    initial begin
        cs = 1'b0; rnw = 1'b1; addr = '0; din = '0; vbl = 1'b0;
        ioctl_addr = '0; debug_bus = '0; rst = 1'b1;
        test_reset();
`ifdef JTSHOUSE_SCR_DBUF_EN
        test_pending();
        test_copy();
        test_prio();
        test_collision();
        test_back_to_back();
        test_reset_midcopy();
`else
        test_direct();
        test_reads();
        test_vbl_ignored();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
